// File: rtl/gp_reg_arb_pkg.sv
// Shared types and widths for the two-requester register-file arbiter.
package gp_reg_arb_pkg;

  localparam int unsigned NUM_REQ   = 2;
  localparam int unsigned REG_IDX_W = 3;
  localparam int unsigned DATA_W    = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/gp_reg_arbiter_rr.sv
// Two-way round-robin pick: the requester not granted last wins a tie.
module rr_arbiter2
  import gp_reg_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last,
  output logic [NUM_REQ-1:0] winner
);

  always_comb begin
    winner = req;
    if (req == 2'b11) winner = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/gp_reg_arbiter.sv
// Arbitrates two requesters onto a shared register file: grant, one access
// cycle driving the rf strobes / data bus, then a done pulse.
module gp_reg_arbiter
  import gp_reg_arb_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   we,
  input  logic [REG_IDX_W-1:0] addr0,
  input  logic [REG_IDX_W-1:0] addr1,
  input  logic [DATA_W-1:0]    wdata0,
  input  logic [DATA_W-1:0]    wdata1,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [DATA_W-1:0]    rdata,
  output logic                 rf_read_data,
  output logic                 rf_write_data,
  output logic [REG_IDX_W-1:0] rf_input_select,
  output logic [REG_IDX_W-1:0] rf_output_select,
  output logic [DATA_W-1:0]    bus_out,
  output logic                 bus_oe,
  input  logic [DATA_W-1:0]    bus_in
);

  state_t               state, state_nx;
  logic                 last_q, last_nx;
  logic                 we_q, we_nx;
  logic [NUM_REQ-1:0]   gnt_nx, done_nx;
  logic [DATA_W-1:0]    rdata_nx, bus_out_nx;
  logic                 rd_nx, wr_nx, oe_nx;
  logic [REG_IDX_W-1:0] isel_nx, osel_nx;

  logic [NUM_REQ-1:0]   win_c;
  logic [REG_IDX_W-1:0] addr_sel_c;
  logic [DATA_W-1:0]    wdata_sel_c;
  logic                 we_sel_c;

  rr_arbiter2 u_rr (
    .req    (req),
    .last   (last_q),
    .winner (win_c)
  );

  always_comb begin
    addr_sel_c  = win_c[1] ? addr1  : addr0;
    wdata_sel_c = win_c[1] ? wdata1 : wdata0;
    we_sel_c    = win_c[1] ? we[1]  : we[0];
  end

  // Next state and next registered outputs; access-cycle outputs are set up
  // on the granting edge so they are clean for the whole ACCESS cycle.
  always_comb begin
    state_nx   = state;
    last_nx    = last_q;
    we_nx      = we_q;
    gnt_nx     = gnt;
    done_nx    = '0;
    rdata_nx   = rdata;
    rd_nx      = 1'b0;
    wr_nx      = 1'b0;
    oe_nx      = 1'b0;
    bus_out_nx = '0;
    isel_nx    = rf_input_select;
    osel_nx    = rf_output_select;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nx = ACCESS;
          gnt_nx   = win_c;
          last_nx  = win_c[1];
          we_nx    = we_sel_c;
          isel_nx  = addr_sel_c;
          osel_nx  = addr_sel_c;
          if (we_sel_c) begin
            rd_nx      = 1'b1;
            oe_nx      = 1'b1;
            bus_out_nx = wdata_sel_c;
          end else begin
            wr_nx = 1'b1;
          end
        end
      end
      ACCESS: begin
        state_nx = RESP;
        done_nx  = gnt;
        if (!we_q) rdata_nx = bus_in;
      end
      RESP: begin
        state_nx = IDLE;
        gnt_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      last_q           <= 1'b1;
      we_q             <= 1'b0;
      gnt              <= '0;
      done             <= '0;
      rdata            <= '0;
      rf_read_data     <= 1'b0;
      rf_write_data    <= 1'b0;
      bus_oe           <= 1'b0;
      bus_out          <= '0;
      rf_input_select  <= '0;
      rf_output_select <= '0;
    end else begin
      state            <= state_nx;
      last_q           <= last_nx;
      we_q             <= we_nx;
      gnt              <= gnt_nx;
      done             <= done_nx;
      rdata            <= rdata_nx;
      rf_read_data     <= rd_nx;
      rf_write_data    <= wr_nx;
      bus_oe           <= oe_nx;
      bus_out          <= bus_out_nx;
      rf_input_select  <= isel_nx;
      rf_output_select <= osel_nx;
    end
  end

endmodule

// File: tb/tb_gp_reg_arbiter.sv
// Directed cycle-vector bench for gp_reg_arbiter plus random-traffic invariants.
module tb_gp_reg_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] req, we;
  logic [2:0] addr0, addr1;
  logic [7:0] wdata0, wdata1, bus_in;
  logic [1:0] gnt, done;
  logic [7:0] rdata, bus_out;
  logic       rf_read_data, rf_write_data, bus_oe;
  logic [2:0] rf_input_select, rf_output_select;

  int total  = 0;
  int passed = 0;

  always #5 clock = ~clock;

  gp_reg_arbiter dut (
    .clock            (clock),
    .reset            (reset),
    .req              (req),
    .we               (we),
    .addr0            (addr0),
    .addr1            (addr1),
    .wdata0           (wdata0),
    .wdata1           (wdata1),
    .gnt              (gnt),
    .done             (done),
    .rdata            (rdata),
    .rf_read_data     (rf_read_data),
    .rf_write_data    (rf_write_data),
    .rf_input_select  (rf_input_select),
    .rf_output_select (rf_output_select),
    .bus_out          (bus_out),
    .bus_oe           (bus_oe),
    .bus_in           (bus_in)
  );

  typedef struct {
    logic       rst;
    logic [1:0] req, we;
    logic [2:0] a0, a1;
    logic [7:0] d0, d1, bin;
    logic [1:0] gnt, done;
    logic [7:0] rdata;
    logic       rrd, rwr;
    logic [2:0] isel, osel;
    logic [7:0] bout;
    logic       oe;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic rst, logic [1:0] rq, logic [1:0] w, logic [2:0] a0, logic [2:0] a1,
                              logic [7:0] d0, logic [7:0] d1, logic [7:0] bin,
                              logic [1:0] g, logic [1:0] dn, logic [7:0] rd, logic rrd, logic rwr,
                              logic [2:0] is, logic [2:0] os, logic [7:0] bo, logic oe);
    vec_t v;
    v.rst = rst; v.req = rq; v.we = w; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.bin = bin;
    v.gnt = g; v.done = dn; v.rdata = rd; v.rrd = rrd; v.rwr = rwr;
    v.isel = is; v.osel = os; v.bout = bo; v.oe = oe;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s @%0d: got %h expected %h", name, idx, got, exp);
  endtask

  initial begin
    // rst req  we  a0 a1 d0     d1     bin      gnt   done  rdata  rd wr is os bout  oe
    vq.push_back(mk(1, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 0, 0, 0, 0, 8'h00, 0));
    // requester 0 writes A5 to r3; inputs changed and req dropped during ACCESS
    vq.push_back(mk(0, 2'b01, 2'b01, 3, 0, 8'hA5, 8'h00, 8'h00, 2'b01, 2'b00, 8'h00, 1, 0, 3, 3, 8'hA5, 1));
    vq.push_back(mk(0, 2'b00, 2'b00, 5, 0, 8'hFF, 8'h00, 8'h00, 2'b01, 2'b01, 8'h00, 0, 0, 3, 3, 8'h00, 0));
    vq.push_back(mk(0, 2'b00, 2'b00, 5, 0, 8'hFF, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 0, 0, 3, 3, 8'h00, 0));
    // requester 0 reads r3, bus returns A5
    vq.push_back(mk(0, 2'b01, 2'b00, 3, 0, 8'h00, 8'h00, 8'h00, 2'b01, 2'b00, 8'h00, 0, 1, 3, 3, 8'h00, 0));
    vq.push_back(mk(0, 2'b01, 2'b00, 3, 0, 8'h00, 8'h00, 8'hA5, 2'b01, 2'b01, 8'hA5, 0, 0, 3, 3, 8'h00, 0));
    vq.push_back(mk(0, 2'b00, 2'b00, 3, 0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 8'hA5, 0, 0, 3, 3, 8'h00, 0));
    // reset, then both request continuously: 0,1,0,1
    vq.push_back(mk(1, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 0, 0, 0, 0, 8'h00, 0));
    vq.push_back(mk(0, 2'b11, 2'b11, 1, 2, 8'h11, 8'h22, 8'h00, 2'b01, 2'b00, 8'h00, 1, 0, 1, 1, 8'h11, 1));
    vq.push_back(mk(0, 2'b11, 2'b11, 1, 2, 8'h11, 8'h22, 8'h00, 2'b01, 2'b01, 8'h00, 0, 0, 1, 1, 8'h00, 0));
    vq.push_back(mk(0, 2'b11, 2'b11, 1, 2, 8'h11, 8'h22, 8'h00, 2'b00, 2'b00, 8'h00, 0, 0, 1, 1, 8'h00, 0));
    vq.push_back(mk(0, 2'b11, 2'b11, 1, 2, 8'h11, 8'h22, 8'h00, 2'b10, 2'b00, 8'h00, 1, 0, 2, 2, 8'h22, 1));
    vq.push_back(mk(0, 2'b11, 2'b11, 1, 2, 8'h11, 8'h22, 8'h00, 2'b10, 2'b10, 8'h00, 0, 0, 2, 2, 8'h00, 0));
    vq.push_back(mk(0, 2'b11, 2'b11, 1, 2, 8'h11, 8'h22, 8'h00, 2'b00, 2'b00, 8'h00, 0, 0, 2, 2, 8'h00, 0));
    vq.push_back(mk(0, 2'b11, 2'b11, 1, 2, 8'h11, 8'h22, 8'h00, 2'b01, 2'b00, 8'h00, 1, 0, 1, 1, 8'h11, 1));
    vq.push_back(mk(0, 2'b11, 2'b11, 1, 2, 8'h11, 8'h22, 8'h00, 2'b01, 2'b01, 8'h00, 0, 0, 1, 1, 8'h00, 0));
    vq.push_back(mk(0, 2'b11, 2'b11, 1, 2, 8'h11, 8'h22, 8'h00, 2'b00, 2'b00, 8'h00, 0, 0, 1, 1, 8'h00, 0));
    vq.push_back(mk(0, 2'b11, 2'b11, 1, 2, 8'h11, 8'h22, 8'h00, 2'b10, 2'b00, 8'h00, 1, 0, 2, 2, 8'h22, 1));
    vq.push_back(mk(0, 2'b11, 2'b11, 1, 2, 8'h11, 8'h22, 8'h00, 2'b10, 2'b10, 8'h00, 0, 0, 2, 2, 8'h00, 0));
    vq.push_back(mk(0, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 0, 0, 2, 2, 8'h00, 0));
    // requester 1 write; addr/wdata change during ACCESS
    vq.push_back(mk(0, 2'b10, 2'b10, 0, 6, 8'h00, 8'h3C, 8'h00, 2'b10, 2'b00, 8'h00, 1, 0, 6, 6, 8'h3C, 1));
    vq.push_back(mk(0, 2'b10, 2'b10, 0, 0, 8'h00, 8'hC3, 8'h00, 2'b10, 2'b10, 8'h00, 0, 0, 6, 6, 8'h00, 0));
    vq.push_back(mk(0, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 0, 0, 6, 6, 8'h00, 0));
    // read from r4 aborted by reset in ACCESS
    vq.push_back(mk(0, 2'b01, 2'b00, 4, 0, 8'h00, 8'h00, 8'h00, 2'b01, 2'b00, 8'h00, 0, 1, 4, 4, 8'h00, 0));
    vq.push_back(mk(1, 2'b01, 2'b00, 4, 0, 8'h00, 8'h00, 8'h77, 2'b00, 2'b00, 8'h00, 0, 0, 0, 0, 8'h00, 0));
    vq.push_back(mk(0, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 0, 0, 0, 0, 8'h00, 0));
    // tie after reset goes to 0; then lone requester 1 reads
    vq.push_back(mk(0, 2'b11, 2'b00, 1, 7, 8'h00, 8'h00, 8'h00, 2'b01, 2'b00, 8'h00, 0, 1, 1, 1, 8'h00, 0));
    vq.push_back(mk(0, 2'b11, 2'b00, 1, 7, 8'h00, 8'h00, 8'h5A, 2'b01, 2'b01, 8'h5A, 0, 0, 1, 1, 8'h00, 0));
    vq.push_back(mk(0, 2'b10, 2'b00, 1, 7, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h5A, 0, 0, 1, 1, 8'h00, 0));
    vq.push_back(mk(0, 2'b10, 2'b00, 1, 7, 8'h00, 8'h00, 8'h00, 2'b10, 2'b00, 8'h5A, 0, 1, 7, 7, 8'h00, 0));
    vq.push_back(mk(0, 2'b10, 2'b00, 1, 7, 8'h00, 8'h00, 8'h99, 2'b10, 2'b10, 8'h99, 0, 0, 7, 7, 8'h00, 0));
    vq.push_back(mk(0, 2'b00, 2'b00, 1, 7, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h99, 0, 0, 7, 7, 8'h00, 0));

    reset = 1'b1; req = '0; we = '0; addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0; bus_in = '0;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clock);
      reset = vq[i].rst; req = vq[i].req; we = vq[i].we;
      addr0 = vq[i].a0; addr1 = vq[i].a1;
      wdata0 = vq[i].d0; wdata1 = vq[i].d1; bus_in = vq[i].bin;
      @(posedge clock);
      #1;
      chk("gnt",   i, 8'(gnt),              8'(vq[i].gnt));
      chk("done",  i, 8'(done),             8'(vq[i].done));
      chk("rdata", i, rdata,                vq[i].rdata);
      chk("rf_rd", i, 8'(rf_read_data),     8'(vq[i].rrd));
      chk("rf_wr", i, 8'(rf_write_data),    8'(vq[i].rwr));
      chk("isel",  i, 8'(rf_input_select),  8'(vq[i].isel));
      chk("osel",  i, 8'(rf_output_select), 8'(vq[i].osel));
      chk("bus_out", i, bus_out,            vq[i].bout);
      chk("bus_oe",  i, 8'(bus_oe),         8'(vq[i].oe));
    end

    // random traffic: exclusivity and grant shape invariants
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      reset = 1'b0;
      req = 2'($urandom_range(0, 3)); we = 2'($urandom_range(0, 3));
      addr0 = 3'($urandom_range(0, 7)); addr1 = 3'($urandom_range(0, 7));
      wdata0 = 8'($urandom); wdata1 = 8'($urandom); bus_in = 8'($urandom);
      @(posedge clock);
      #1;
      chk("rd_and_wr", c, 8'(rf_read_data & rf_write_data), 8'h00);
      chk("oe_and_wr", c, 8'(bus_oe & rf_write_data), 8'h00);
      chk("gnt_onehot0", c, 8'($countones(gnt) <= 1), 8'h01);
      chk("done_in_gnt", c, 8'(done & ~gnt), 8'h00);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/gp_reg_arbiter.md
GP_REG_ARBITER -- requirements
Module: gp_reg_arbiter

Interface
REQ-001 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clock, in, 1, rising-edge clock.
- reset, in, 1, synchronous, active-high reset.
- req[1:0], in, 2, per-requester access request; held high until the matching done.
- we[1:0], in, 2, per requester: 1 = write wdata into a register, 0 = read a register.
- addr0 / addr1, in, 3 each, register index per requester.
- wdata0 / wdata1, in, 8 each, write data per requester.
- gnt[1:0], out, 2, one-hot grant, high for the whole transaction.
- done[1:0], out, 2, one-cycle completion pulse per requester.
- rdata, out, 8, read result, valid in the done cycle.
- rf_read_data, out, 1, register-file load strobe.
- rf_write_data, out, 1, register-file bus-drive enable.
- rf_input_select, out, 3, register-file load index.
- rf_output_select, out, 3, register-file output index.
- bus_out, out, 8, value driven onto the data bus.
- bus_oe, out, 1, arbiter bus-driver enable.
- bus_in, in, 8, sampled data bus.

REQ-002 The reset input is reset: synchronous, active-high. The clock input is clock.

Function
REQ-003 The FSM SHALL have three states: IDLE, ACCESS, RESP.
REQ-004 IDLE: if any req bit is high, the block SHALL latch the winner's index, we, addr and wdata, assert gnt[winner], and go to ACCESS on the next edge; otherwise it stays in IDLE.
REQ-005 Arbitration SHALL be round-robin: the requester not granted last wins a tie; a lone requester always wins.
REQ-006 ACCESS, write: rf_read_data=1, bus_oe=1, bus_out=latched wdata, rf_input_select=latched addr, rf_write_data=0.
REQ-007 ACCESS, read: rf_write_data=1, bus_oe=0, rf_output_select=latched addr; rdata SHALL capture bus_in on the exiting edge.
REQ-008 In ACCESS, rf_read_data and rf_write_data SHALL never both be 1, and bus_oe SHALL never be 1 together with rf_write_data.
REQ-009 ACCESS SHALL go to RESP after exactly one cycle.
REQ-010 RESP: done[winner]=1 for one cycle, gnt held, all rf strobes and bus_oe 0; next state IDLE.
REQ-011 Outside ACCESS, all rf strobes, bus_oe and bus_out SHALL be 0; select outputs hold the last latched addr.
REQ-012 Latency: req high at edge k (state IDLE) -> ACCESS in cycle k+1, done in cycle k+2; back-to-back transactions take 3 cycles each.
REQ-013 Changes to a granted requester's inputs after grant SHALL be ignored (latched copy used); req dropped early SHALL NOT abort the transaction.
REQ-014 rdata SHALL hold its value until the next read completes; writes SHALL leave rdata unchanged.
REQ-015 A request arriving in ACCESS or RESP SHALL wait; it is not lost.

Reset
REQ-016 On reset: state=IDLE, gnt=0, done=0, rdata=0, all rf strobes/bus_oe/bus_out=0, selects=0, last-grant pointer=1 (requester 0 wins the first tie).
REQ-017 Reset in ACCESS or RESP SHALL abort the transaction with no done pulse; a write in progress at that edge is not guaranteed.

Structure
REQ-018 The shared package gp_reg_arb_pkg SHALL hold the state enum, NUM_REQ=2, REG_IDX_W=3 and DATA_W=8.
REQ-019 Round-robin selection SHALL live in the sub-module rr_arbiter2 (inputs req and last; output one-hot winner). The FSM and datapath latches stay in the top level.

Verification
REQ-020 Write then read: requester 0 writes 8'hA5 to r3, then reads r3 -> the write has rf_input_select=3 and bus_out=A5; the read returns rdata=A5 in its done cycle.
REQ-021 Simultaneous req=2'b11 directly after reset -> grant order 0, 1, 0, 1 in alternation; each transaction is 3 cycles.
REQ-022 Requester 1 changes addr and wdata during ACCESS -> the latched values are used; no glitch on rf_input_select.
REQ-023 Reset asserted in ACCESS of a read -> no done pulse; all outputs are at their reset values the next cycle.
REQ-024 Exclusivity check: across random traffic, rf_read_data&rf_write_data and bus_oe&rf_write_data are never 1, and gnt is always one-hot or zero.
